// File: rtl/data_ram_pkg.sv
// data_ram_pkg: size encodings and byte-lane helpers shared by data_ram_pipe.
package data_ram_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    // Number of bytes touched by an access of the given size.
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'(1 << size);
    endfunction

    // Byte-lane mask for an access of the given size starting at lane 'off'.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        return 8'(((16'd1 << size_bytes(size)) - 16'd1) << off);
    endfunction

    // Sign- or zero-extend right-aligned load data from the top selected byte.
    function automatic logic [63:0] extend_load(input logic [63:0] data,
                                                input logic [1:0]  size,
                                                input logic        us);
        logic [63:0] result;
        result = data;
        case (size)
            SZ_B:    result = us ? {56'd0, data[7:0]}  : {{56{data[7]}},  data[7:0]};
            SZ_H:    result = us ? {48'd0, data[15:0]} : {{48{data[15]}}, data[15:0]};
            SZ_W:    result = us ? {32'd0, data[31:0]} : {{32{data[31]}}, data[31:0]};
            default: result = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/data_ram_bank.sv
// data_ram_bank: one byte lane of storage, synchronous read-first RAM.
// The read register holds its value while en is low; contents are never reset.
module data_ram_bank #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);

    logic [7:0] mem [DEPTH];

    // Read-first access: rdata shows the old byte even on the write edge.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_ram_pipe.sv
// data_ram_pipe: two-stage MEM-stage data memory with valid/ready request and
// registered response. Stage S1 covers the RAM access, S2 is the response.
// Optional feature: define DATA_RAM_MISALIGN_TRAP_EN to report misaligned
// accesses as errors; otherwise misaligned offsets are aligned down.
module data_ram_pipe
    import data_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_us,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int IDX_W = $clog2(DEPTH);

    logic              stall;
    logic              accept;
    logic              ram_en;
    logic [OFF_W-1:0]  req_off;
    logic [OFF_W-1:0]  align_mask;
    logic [OFF_W-1:0]  eff_off;
    logic [IDX_W-1:0]  req_idx;
    logic              req_illegal;
    logic              req_misaligned;
    logic              req_err;
    logic [LANES-1:0]  wr_lanes;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] ld_shift;
    logic [DATA_W-1:0] ld_data;
    logic              unused_addr;

    logic              v1;
    logic              we1;
    logic              us1;
    logic              err1;
    logic [1:0]        size1;
    logic [OFF_W-1:0]  off1;

    assign stall     = rsp_valid && !rsp_ready;
    assign req_ready = !stall;
    assign accept    = req_valid && req_ready;
    assign ram_en    = !stall;

    assign req_off     = req_addr[OFF_W-1:0];
    assign req_idx     = req_addr[OFF_W+IDX_W-1:OFF_W];
    assign unused_addr = ^req_addr[ADDR_W-1:OFF_W+IDX_W];
    assign align_mask  = OFF_W'(size_bytes(req_size) - 4'd1);
    assign req_illegal = (DATA_W == 32) && (req_size == SZ_D);

`ifdef DATA_RAM_MISALIGN_TRAP_EN
    assign req_misaligned = (req_off & align_mask) != '0;
    assign eff_off        = req_off;
`else
    assign req_misaligned = 1'b0;
    assign eff_off        = req_off & ~align_mask;
`endif

    assign req_err  = req_illegal || req_misaligned;
    assign wr_lanes = (accept && req_we && !req_err)
                    ? LANES'(lane_mask(req_size, 3'(eff_off))) : '0;
    // Only the masked lanes are written, so shifting the right-aligned data
    // up to the offset places every selected byte in its lane.
    assign wr_data  = req_wdata << {eff_off, 3'b000};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        data_ram_bank #(.DEPTH(DEPTH)) u_bank (
            .clk   (clk),
            .en    (ram_en),
            .we    (wr_lanes[i]),
            .addr  (req_idx),
            .wdata (wr_data[8*i +: 8]),
            .rdata (ram_rdata[8*i +: 8])
        );
    end

    assign ld_shift = ram_rdata >> {off1, 3'b000};
    assign ld_data  = DATA_W'(extend_load(64'(ld_shift), size1, us1));

    // S1 captures the accepted request while the RAM read is in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1    <= 1'b0;
            we1   <= 1'b0;
            us1   <= 1'b0;
            err1  <= 1'b0;
            size1 <= 2'b00;
            off1  <= '0;
        end else if (!stall) begin
            v1    <= accept;
            we1   <= req_we;
            us1   <= req_us;
            err1  <= req_err;
            size1 <= req_size;
            off1  <= eff_off;
        end
    end

    // S2 forms the response; stores and errors return zero data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (!stall) begin
            rsp_valid <= v1;
            rsp_err   <= v1 && err1;
            rsp_rdata <= (v1 && !we1 && !err1) ? ld_data : '0;
        end
    end

endmodule
